// File: rtl/clct_two_pass_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : clct_two_pass_sequencer_if
// Brief   : Start/ready handshake, sorter link and result bus of the sequencer.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface clct_two_pass_sequencer_if #(
   parameter int MXKEY  = 32,
   parameter int MXKEYB = 5,
   parameter int MXPATB = 7,
   parameter int MXPATC = 12
);
   logic              start;
   logic [MXKEY-1:0]  ext_bsy;
   logic              ready;
   logic [MXKEY-1:0]  sort_bsy;
   logic [MXPATB-1:0] best_pat;
   logic [MXKEYB-1:0] best_key;
   logic [MXPATC-1:0] best_carry;
   logic              best_bsy;
   logic              done;
   logic              first_vld;
   logic [MXPATB-1:0] first_pat;
   logic [MXKEYB-1:0] first_key;
   logic [MXPATC-1:0] first_carry;
   logic              second_vld;
   logic [MXPATB-1:0] second_pat;
   logic [MXKEYB-1:0] second_key;
   logic [MXPATC-1:0] second_carry;

   modport slave (
      input  start, ext_bsy, best_pat, best_key, best_carry, best_bsy,
      output ready, sort_bsy, done,
             first_vld, first_pat, first_key, first_carry,
             second_vld, second_pat, second_key, second_carry
   );

   modport master (
      output start, ext_bsy, best_pat, best_key, best_carry, best_bsy,
      input  ready, sort_bsy, done,
             first_vld, first_pat, first_key, first_carry,
             second_vld, second_pat, second_key, second_carry
   );
endinterface
`default_nettype wire

// File: rtl/clct_two_pass_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : clct_two_pass_sequencer
// Brief   : Drives the best-1-of-32 sorter twice to extract best and second-best keys.
// Revision: 1.0
// ---------------------------------------------------------------------------
module clct_two_pass_sequencer #(
   parameter int MXKEY    = 32,
   parameter int MXKEYB   = 5,
   parameter int MXPATB   = 7,
   parameter int MXPATC   = 12,
   parameter int SPREAD   = 2,
   parameter int SORT_LAT = 1,
   parameter int DEADTIME = 4
) (
   input  logic clock,
   input  logic reset_n,
   clct_two_pass_sequencer_if.slave bus
);
   localparam int KW     = MXKEYB + 2;
   localparam int CNTMAX = (SORT_LAT > DEADTIME) ? SORT_LAT : DEADTIME;
   localparam int CNTW   = (CNTMAX > 0) ? $clog2(CNTMAX + 1) : 1;

   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_PASS1 = 3'd1;
   localparam logic [2:0] c_PASS2 = 3'd2;
   localparam logic [2:0] c_DONE  = 3'd3;
   localparam logic [2:0] c_DEAD  = 3'd4;
   localparam logic [2:0] c_AFTER_DONE = (DEADTIME > 0) ? c_DEAD : c_IDLE;

   localparam logic signed [KW-1:0] c_SPREAD   = KW'(SPREAD);
   localparam logic [CNTW-1:0]      c_PASS_END = CNTW'(SORT_LAT);
   localparam logic [CNTW-1:0]      c_DEAD_END = CNTW'(DEADTIME - 1);

   logic [2:0]        r_state;
   logic [CNTW-1:0]   r_cnt;
   logic [MXKEY-1:0]  r_bmask;
   logic [MXKEY-1:0]  r_sort_bsy;
   logic [MXPATB-1:0] r_h_pat;
   logic [MXKEYB-1:0] r_h_key;
   logic [MXPATC-1:0] r_h_carry;
   logic              r_done;
   logic              r_first_vld;
   logic [MXPATB-1:0] r_first_pat;
   logic [MXKEYB-1:0] r_first_key;
   logic [MXPATC-1:0] r_first_carry;
   logic              r_second_vld;
   logic [MXPATB-1:0] r_second_pat;
   logic [MXKEYB-1:0] r_second_key;
   logic [MXPATC-1:0] r_second_carry;

   logic                 w_hit;
   logic                 w_pass_last;
   logic signed [KW-1:0] w_lo;
   logic signed [KW-1:0] w_hi;
   logic [MXKEY-1:0]     w_win;

   assign w_hit       = !bus.best_bsy && (bus.best_pat[MXPATB-1:1] != '0);
   assign w_pass_last = (r_cnt == c_PASS_END);

   // Window bounds may fall outside 0..MXKEY-1; the signed compare clips them.
   assign w_lo = $signed({2'b00, bus.best_key}) - c_SPREAD;
   assign w_hi = $signed({2'b00, bus.best_key}) + c_SPREAD;

   for (genvar j = 0; j < MXKEY; j++) begin : g_win
      localparam logic signed [KW-1:0] c_J = KW'(j);
      assign w_win[j] = (c_J >= w_lo) && (c_J <= w_hi);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state        <= c_IDLE;
         r_cnt          <= '0;
         r_bmask        <= '0;
         r_sort_bsy     <= '0;
         r_h_pat        <= '0;
         r_h_key        <= '0;
         r_h_carry      <= '0;
         r_done         <= 1'b0;
         r_first_vld    <= 1'b0;
         r_first_pat    <= '0;
         r_first_key    <= '0;
         r_first_carry  <= '0;
         r_second_vld   <= 1'b0;
         r_second_pat   <= '0;
         r_second_key   <= '0;
         r_second_carry <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (bus.start) begin
                  r_bmask    <= bus.ext_bsy;
                  r_sort_bsy <= bus.ext_bsy;
                  r_cnt      <= '0;
                  r_state    <= c_PASS1;
               end
            end
            c_PASS1: begin
               if (w_pass_last) begin
                  r_cnt     <= '0;
                  r_h_pat   <= bus.best_pat;
                  r_h_key   <= bus.best_key;
                  r_h_carry <= bus.best_carry;
                  if (w_hit) begin
                     r_sort_bsy <= r_bmask | w_win;
                     r_state    <= c_PASS2;
                  end else begin
                     // No first hit: publish an all-invalid result right away.
                     r_sort_bsy     <= '0;
                     r_state        <= c_DONE;
                     r_done         <= 1'b1;
                     r_first_vld    <= 1'b0;
                     r_first_pat    <= '0;
                     r_first_key    <= '0;
                     r_first_carry  <= '0;
                     r_second_vld   <= 1'b0;
                     r_second_pat   <= '0;
                     r_second_key   <= '0;
                     r_second_carry <= '0;
                  end
               end else begin
                  r_cnt <= r_cnt + CNTW'(1);
               end
            end
            c_PASS2: begin
               if (w_pass_last) begin
                  r_cnt          <= '0;
                  r_sort_bsy     <= '0;
                  r_state        <= c_DONE;
                  r_done         <= 1'b1;
                  r_first_vld    <= 1'b1;
                  r_first_pat    <= r_h_pat;
                  r_first_key    <= r_h_key;
                  r_first_carry  <= r_h_carry;
                  r_second_vld   <= w_hit;
                  r_second_pat   <= w_hit ? bus.best_pat   : '0;
                  r_second_key   <= w_hit ? bus.best_key   : '0;
                  r_second_carry <= w_hit ? bus.best_carry : '0;
               end else begin
                  r_cnt <= r_cnt + CNTW'(1);
               end
            end
            c_DONE: begin
               r_cnt   <= '0;
               r_state <= c_AFTER_DONE;
            end
            c_DEAD: begin
               if (r_cnt == c_DEAD_END) begin
                  r_cnt   <= '0;
                  r_state <= c_IDLE;
               end else begin
                  r_cnt <= r_cnt + CNTW'(1);
               end
            end
            default: begin
               r_sort_bsy <= '0;
               r_cnt      <= '0;
               r_state    <= c_IDLE;
            end
         endcase
      end
   end

   assign bus.ready        = (r_state == c_IDLE);
   assign bus.sort_bsy     = r_sort_bsy;
   assign bus.done         = r_done;
   assign bus.first_vld    = r_first_vld;
   assign bus.first_pat    = r_first_pat;
   assign bus.first_key    = r_first_key;
   assign bus.first_carry  = r_first_carry;
   assign bus.second_vld   = r_second_vld;
   assign bus.second_pat   = r_second_pat;
   assign bus.second_key   = r_second_key;
   assign bus.second_carry = r_second_carry;
endmodule
`default_nettype wire

// File: tb/tb_clct_two_pass_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_clct_two_pass_sequencer
// Brief   : Directed bench with a one-clock sorter model for the two-pass sequencer.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_clct_two_pass_sequencer;
   localparam int MXKEY  = 32;
   localparam int MXKEYB = 5;
   localparam int MXPATB = 7;
   localparam int MXPATC = 12;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   int   tests   = 0;
   int   fails   = 0;

   logic [MXPATB-1:0] pats    [MXKEY];
   logic [MXPATC-1:0] carries [MXKEY];

   logic              c_found;
   logic [MXPATB-1:0] c_pat;
   logic [MXKEYB-1:0] c_key;
   logic [MXPATC-1:0] c_carry;

   clct_two_pass_sequencer_if #(
      .MXKEY(MXKEY), .MXKEYB(MXKEYB), .MXPATB(MXPATB), .MXPATC(MXPATC)
   ) bus ();

   clct_two_pass_sequencer #(
      .MXKEY(MXKEY), .MXKEYB(MXKEYB), .MXPATB(MXPATB), .MXPATC(MXPATC),
      .SPREAD(2), .SORT_LAT(1), .DEADTIME(4)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   // Sorter: highest rank among non-busy keys, lowest key on ties, one clock latency.
   always_comb begin
      c_found = 1'b0;
      c_pat   = '0;
      c_key   = '0;
      c_carry = '0;
      for (int k = 0; k < MXKEY; k++) begin
         if (!bus.sort_bsy[k] && (!c_found || (pats[k][MXPATB-1:1] > c_pat[MXPATB-1:1]))) begin
            c_found = 1'b1;
            c_pat   = pats[k];
            c_key   = MXKEYB'(k);
            c_carry = carries[k];
         end
      end
   end

   always_ff @(posedge clock) begin
      bus.best_pat   <= c_pat;
      bus.best_key   <= c_key;
      bus.best_carry <= c_carry;
      bus.best_bsy   <= !c_found;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_pats();
      for (int k = 0; k < MXKEY; k++) pats[k] = '0;
   endtask

   initial begin
      for (int k = 0; k < MXKEY; k++) carries[k] = MXPATC'(256 + k);
      clear_pats();
      bus.start   = 1'b0;
      bus.ext_bsy = '0;

      // Reset state
      reset_n = 1'b0;
      tick();
      tick();
      check("rst_ready",     32'(bus.ready),      32'h1);
      check("rst_done",      32'(bus.done),       32'h0);
      check("rst_sort_bsy",  bus.sort_bsy,        32'h0);
      check("rst_first_vld", 32'(bus.first_vld),  32'h0);
      check("rst_second_vld",32'(bus.second_vld), 32'h0);
      reset_n = 1'b1;
      tick();

      // 1: two hits, window 3..7 around key 5
      pats[5] = 7'h7E; pats[20] = 7'h60;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("t1_ready_clk1", 32'(bus.ready), 32'h0);
      check("t1_bsy_pass1",  bus.sort_bsy,   32'h0);
      tick(); tick();
      check("t1_bsy_pass2",  bus.sort_bsy,   32'h0000_00F8);
      tick();
      check("t1_done_clk4",  32'(bus.done),  32'h0);
      tick();
      check("t1_done_clk5",  32'(bus.done),         32'h1);
      check("t1_first_vld",  32'(bus.first_vld),    32'h1);
      check("t1_first_key",  32'(bus.first_key),    32'd5);
      check("t1_first_pat",  32'(bus.first_pat),    32'h7E);
      check("t1_first_carry",32'(bus.first_carry),  32'h105);
      check("t1_second_vld", 32'(bus.second_vld),   32'h1);
      check("t1_second_key", 32'(bus.second_key),   32'd20);
      check("t1_second_pat", 32'(bus.second_pat),   32'h60);
      check("t1_second_carry",32'(bus.second_carry),32'h114);
      check("t1_bsy_done",   bus.sort_bsy,          32'h0);
      tick();
      check("t1_done_pulse", 32'(bus.done),      32'h0);
      check("t1_hold_key",   32'(bus.first_key), 32'd5);
      tick(); tick(); tick();
      check("t1_ready_clk9", 32'(bus.ready), 32'h0);
      tick();
      check("t1_ready_clk10",32'(bus.ready), 32'h1);

      // 2: window clipped at key 0, key 2 masked
      clear_pats();
      pats[1] = 7'h7E; pats[2] = 7'h70; pats[10] = 7'h40;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick(); tick();
      check("t2_bsy_pass2",  bus.sort_bsy, 32'h0000_000F);
      tick(); tick();
      check("t2_done",       32'(bus.done),       32'h1);
      check("t2_first_key",  32'(bus.first_key),  32'd1);
      check("t2_second_vld", 32'(bus.second_vld), 32'h1);
      check("t2_second_key", 32'(bus.second_key), 32'd10);
      check("t2_second_pat", 32'(bus.second_pat), 32'h40);
      repeat (5) tick();
      check("t2_ready_back", 32'(bus.ready), 32'h1);

      // 3: no pattern at all
      clear_pats();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      check("t3_done_clk2",  32'(bus.done), 32'h0);
      tick();
      check("t3_done_clk3",  32'(bus.done),       32'h1);
      check("t3_first_vld",  32'(bus.first_vld),  32'h0);
      check("t3_first_pat",  32'(bus.first_pat),  32'h0);
      check("t3_second_vld", 32'(bus.second_vld), 32'h0);
      check("t3_second_key", 32'(bus.second_key), 32'h0);
      check("t3_no_pass2",   bus.sort_bsy,        32'h0);
      repeat (4) tick();
      check("t3_ready_clk7", 32'(bus.ready), 32'h0);
      tick();
      check("t3_ready_clk8", 32'(bus.ready), 32'h1);

      // 4: all keys busy; ext_bsy changes after acceptance are ignored
      pats[7] = 7'h7E;
      bus.ext_bsy = 32'hFFFF_FFFF;
      bus.start = 1'b1;
      tick();
      bus.start   = 1'b0;
      bus.ext_bsy = '0;
      check("t4_bsy_latched", bus.sort_bsy, 32'hFFFF_FFFF);
      tick();
      check("t4_bsy_held",    bus.sort_bsy, 32'hFFFF_FFFF);
      tick();
      check("t4_done_clk3",  32'(bus.done),       32'h1);
      check("t4_first_vld",  32'(bus.first_vld),  32'h0);
      check("t4_second_vld", 32'(bus.second_vld), 32'h0);
      repeat (5) tick();
      check("t4_ready_back", 32'(bus.ready), 32'h1);

      // 5: start held high every clock
      clear_pats();
      pats[5] = 7'h7E; pats[20] = 7'h60;
      bus.start = 1'b1;
      check("t5_ready_clk0", 32'(bus.ready), 32'h1);
      for (int n = 1; n <= 10; n++) begin
         tick();
         check($sformatf("t5_ready_clk%0d", n), 32'(bus.ready), (n == 10) ? 32'h1 : 32'h0);
         if (n == 5) check("t5_done_clk5", 32'(bus.done), 32'h1);
      end
      tick();
      bus.start = 1'b0;
      check("t5_accept_clk10", 32'(bus.ready), 32'h0);

      // 6: reset at clk3 of the sequence accepted at clk10
      tick(); tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("t6_ready",      32'(bus.ready),      32'h1);
      check("t6_done",       32'(bus.done),       32'h0);
      check("t6_first_vld",  32'(bus.first_vld),  32'h0);
      check("t6_first_key",  32'(bus.first_key),  32'h0);
      check("t6_first_pat",  32'(bus.first_pat),  32'h0);
      check("t6_second_vld", 32'(bus.second_vld), 32'h0);
      check("t6_second_key", 32'(bus.second_key), 32'h0);
      check("t6_sort_bsy",   bus.sort_bsy,        32'h0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("t6_restart", 32'(bus.ready), 32'h0);
      repeat (4) tick();
      check("t6_done_new",   32'(bus.done),       32'h1);
      check("t6_first_new",  32'(bus.first_key),  32'd5);
      check("t6_second_new", 32'(bus.second_key), 32'd20);

      // 7: simultaneous reset and start, reset wins
      reset_n   = 1'b0;
      bus.start = 1'b1;
      tick();
      reset_n   = 1'b1;
      bus.start = 1'b0;
      check("t7_ready",    32'(bus.ready), 32'h1);
      check("t7_sort_bsy", bus.sort_bsy,   32'h0);
      check("t7_done",     32'(bus.done),  32'h0);
      tick();
      check("t7_still_idle", 32'(bus.ready), 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
